// File: rtl/rv_elastic_buffer.sv
// Ready/valid elastic buffer: DEPTH-entry circular store decoupling upstream and downstream backpressure.
// Optional zero-latency pass-through when empty is enabled by defining RV_BYPASS_EN.
module rv_elastic_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   // state      | meaning
   // ST_EMPTY   | no words stored (count == 0)
   // ST_PARTIAL | 0 < count < DEPTH
   // ST_FULL    | count == DEPTH, upstream stalled

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } state_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rv_elastic_buffer: DEPTH must be a power of two >= 2");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count_q;
   state_t                state;
   logic                  push;
   logic                  pop;
   logic                  pass_thru;
   logic                  wr_en;
   logic                  rd_en;

   assign count    = count_q;
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign in_ready = !full;

`ifdef RV_BYPASS_EN
   // An empty buffer forwards the upstream word directly; it is only stored if downstream stalls.
   assign out_valid = (state != ST_EMPTY) || in_valid;
   assign out_data  = empty ? in_data : mem[rd_ptr];
   assign pass_thru = empty && in_valid && out_ready;
`else
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = mem[rd_ptr];
   assign pass_thru = 1'b0;
`endif

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   assign wr_en = push && !pass_thru && !flush;
   assign rd_en = pop && !pass_thru && !flush;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         state   <= ST_EMPTY;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         state   <= ST_EMPTY;
      end else begin
         case ({wr_en, rd_en})
            2'b10: begin
               wr_ptr  <= wr_ptr + ONE_PTR;
               count_q <= count_q + ONE_CNT;
               state   <= (count_q == LAST_CNT) ? ST_FULL : ST_PARTIAL;
            end
            2'b01: begin
               rd_ptr  <= rd_ptr + ONE_PTR;
               count_q <= count_q - ONE_CNT;
               state   <= (count_q == ONE_CNT) ? ST_EMPTY : ST_PARTIAL;
            end
            2'b11: begin
               wr_ptr <= wr_ptr + ONE_PTR;
               rd_ptr <= rd_ptr + ONE_PTR;
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Self-checking bench for rv_elastic_buffer: vector table, hand sequences and a queue-based random scoreboard.
module tb_rv_elastic_buffer;

   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef RV_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk;
   logic             reset_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   rv_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] q[$];
   int model_pops = 0;
   int dut_pops   = 0;

   typedef struct {
      logic          f;
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          ev;
      logic [DW-1:0] ed;
      int            ec;
      logic          ef;
      logic          eir;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle against the queue model; entered and left 1 time unit after a rising edge.
   task automatic cyc(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
      logic          exp_ov;
      logic [DW-1:0] exp_od;
      logic          push_e;
      logic          pop_e;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #3;
      exp_ov = (q.size() > 0) || (BYP && iv);
      exp_od = (q.size() > 0) ? q[0] : d;
      chk("count", DW'(count), DW'(q.size()));
      chk("full", DW'(full), DW'(q.size() == DEPTH));
      chk("empty", DW'(empty), DW'(q.size() == 0));
      chk("in_ready", DW'(in_ready), DW'(q.size() != DEPTH));
      chk("out_valid", DW'(out_valid), DW'(exp_ov));
      if (exp_ov) chk("out_data", out_data, exp_od);
      if (out_valid && ordy && !f) dut_pops++;
      push_e = iv && (q.size() < DEPTH);
      pop_e  = exp_ov && ordy;
      @(posedge clk);
      if (f) begin
         q.delete();
      end else if (BYP && q.size() == 0 && iv && ordy) begin
         model_pops++;
      end else begin
         if (pop_e) begin
            void'(q.pop_front());
            model_pops++;
         end
         if (push_e) q.push_back(d);
      end
      #1;
   endtask

   initial begin
      int p0;
      int ncyc;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      chk("reset_count", DW'(count), 0);
      chk("reset_out_valid", DW'(out_valid), 0);
      chk("reset_empty", DW'(empty), 1);
      chk("reset_full", DW'(full), 0);
      chk("reset_in_ready", DW'(in_ready), 1);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      // {flush, in_valid, in_data, out_ready, exp valid, exp data, exp count, exp full, exp in_ready}
      vecs[0]  = '{1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 64'h11, 1, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 64'h22, 1'b0, 1'b1, 64'h11, 2, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 64'h33, 1'b0, 1'b1, 64'h11, 3, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 64'h44, 1'b0, 1'b1, 64'h11, 4, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 64'h55, 1'b0, 1'b1, 64'h11, 4, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 64'h22, 3, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 64'h33, 2, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 64'h44, 1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 64'h00, 0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 64'h66, 1'b0, 1'b1, 64'h66, 1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 64'h77, 1'b0, 1'b1, 64'h66, 2, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 64'h88, 1'b1, 1'b0, 64'h00, 0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 64'h99, 1'b0, 1'b1, 64'h99, 1, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 64'h00, 0, 1'b0, 1'b1};
      for (int i = 0; i < 14; i++) begin
         flush = vecs[i].f; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         @(posedge clk); #1;
         flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
         #1;
         chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].ev));
         if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
         chk($sformatf("vec%0d_count", i), DW'(count), DW'(vecs[i].ec));
         chk($sformatf("vec%0d_full", i), DW'(full), DW'(vecs[i].ef));
         chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].eir));
      end

      // Asynchronous reset mid-burst with three words held.
      cyc(1'b0, 1'b1, 64'hA1, 1'b0);
      cyc(1'b0, 1'b1, 64'hA2, 1'b0);
      cyc(1'b0, 1'b1, 64'hA3, 1'b0);
      in_valid = 1'b1; in_data = 64'hA4;
      #3;
      chk("pre_reset_count", DW'(count), 3);
      reset_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("midreset_count", DW'(count), 0);
      chk("midreset_out_valid", DW'(out_valid), 0);
      chk("midreset_in_ready", DW'(in_ready), 1);
      chk("midreset_empty", DW'(empty), 1);
      q.delete();
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      cyc(1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);

      // Streaming: one word per cycle, order kept, count constant.
      p0 = dut_pops;
      for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, DW'(1000 + i), 1'b1);
      chk("stream_words", DW'(dut_pops - p0), BYP ? 64'd100 : 64'd99);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);

      // Flush coinciding with a push at count=2: pushed word must never appear.
      cyc(1'b0, 1'b1, 64'hB1, 1'b0);
      cyc(1'b0, 1'b1, 64'hB2, 1'b0);
      cyc(1'b1, 1'b1, 64'hDEAD, 1'b1);
      chk("flush_empty", DW'(empty), 1);
      p0 = dut_pops;
      cyc(1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);
      chk("flush_no_emit", DW'(dut_pops - p0), 0);

      // Bypass behaviour from empty: same-cycle with the macro, one cycle later without.
      flush = 1'b0; in_valid = 1'b1; in_data = 64'hABCD; out_ready = 1'b1;
      #1;
      chk("bypass_same_cycle_valid", DW'(out_valid), DW'(BYP));
      #1;
      cyc(1'b0, 1'b1, 64'hABCD, 1'b1);
      chk("bypass_count_after", DW'(count), BYP ? 64'd0 : 64'd1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1);

      // Random 50% valid/ready traffic with rare flushes against the queue model.
      p0 = model_pops;
      ncyc = 0;
      while ((model_pops - p0) < 10000 && ncyc < 60000) begin
         cyc(($urandom_range(0, 255) == 0), $urandom_range(0, 1) == 1,
             {$urandom, $urandom}, $urandom_range(0, 1) == 1);
         ncyc++;
      end
      chk("random_words_done", DW'((model_pops - p0) >= 10000), 1);
      chk("random_wraps", DW'(((model_pops - p0) / DEPTH) >= 2000), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
